// File: rtl/adc_pkg.sv
// Shared types and default widths for the ADC scan sequencer.
package adc_pkg;

  localparam int unsigned ADC_CH_W   = 5;
  localparam int unsigned ADC_DATA_W = 12;

  typedef enum logic [2:0] {
    IDLE,
    SEL,
    CMD,
    WAIT,
    EMIT,
    END
  } scan_state_t;

endpackage

// File: rtl/adc_avg_acc.sv
// Sample accumulator for one scan entry: sums 2^AVG_LOG2 samples and
// presents the truncated average of the running sum plus the incoming sample.
module adc_avg_acc #(
  parameter int unsigned DATA_W   = 12,
  parameter int unsigned AVG_LOG2 = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_clear,
  input  logic              i_add,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_full,      // the add presented now completes the set
  output logic [DATA_W-1:0] o_avg_next   // average including i_data
);

  localparam int unsigned ACC_W = DATA_W + AVG_LOG2;
  localparam int unsigned CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'((2 ** AVG_LOG2) - 1);

  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic [ACC_W-1:0] w_sum;

  assign w_sum      = r_acc + ACC_W'(i_data);
  assign o_avg_next = w_sum[ACC_W-1:AVG_LOG2];
  assign o_full     = (r_cnt == LAST);

  // Running sum and sample count; clear wins over add.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (i_clear) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (i_add) begin
      r_acc <= w_sum;
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/adc_scan_ctrl.sv
// Scan-list sequencer for the modular ADC core: issues one command per
// conversion, averages per entry and reports results, pass ends and errors.
module adc_scan_ctrl
  import adc_pkg::*;
#(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned CH_W     = ADC_CH_W,
  parameter int unsigned DATA_W   = ADC_DATA_W,
  parameter int unsigned AVG_LOG2 = 2,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic                       continuous,
  input  logic [NUM_CH*CH_W-1:0]     ch_list,
  input  logic [NUM_CH-1:0]          ch_en,
  output logic                       command_valid,
  output logic [CH_W-1:0]            command_channel,
  output logic                       command_startofpacket,
  output logic                       command_endofpacket,
  input  logic                       command_ready,
  input  logic                       response_valid,
  input  logic [CH_W-1:0]            response_channel,
  input  logic [DATA_W-1:0]          response_data,
  output logic                       res_valid,
  output logic [$clog2(NUM_CH)-1:0]  res_index,
  output logic [DATA_W-1:0]          res_data,
  output logic                       busy,
  output logic                       scan_done,
  output logic                       err_timeout,
  output logic                       err_chan
);

  localparam int unsigned IDX_W = $clog2(NUM_CH);
  localparam int unsigned POS_W = IDX_W + 1;  // one extra bit to mark "past the last entry"
  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

  scan_state_t       r_state;
  logic [CH_W-1:0]   r_chan [NUM_CH];
  logic [NUM_CH-1:0] r_en;
  logic [POS_W-1:0]  r_idx;
  logic [TMR_W-1:0]  r_tmr;
  logic              r_cmd_valid;
  logic [CH_W-1:0]   r_cmd_chan;
  logic              r_res_valid;
  logic [IDX_W-1:0]  r_res_index;
  logic [DATA_W-1:0] r_res_data;
  logic              r_scan_done;
  logic              r_err_to;
  logic              r_err_chan;

  logic              w_load;
  logic              w_found;
  logic [IDX_W-1:0]  w_sel;
  logic              w_match;
  logic              w_add;
  logic              w_timeout;
  logic              w_clear;
  logic              w_full;
  logic [DATA_W-1:0] w_avg;

  assign w_load    = ((r_state == IDLE) && start) || ((r_state == END) && continuous);
  assign w_match   = (response_channel == r_cmd_chan);
  assign w_add     = (r_state == WAIT) && response_valid && w_match;
  assign w_timeout = (r_state == WAIT) && !response_valid && (r_tmr == TMR_W'(TIMEOUT));
  assign w_clear   = (r_state == EMIT) || w_timeout;

  // First enabled entry at or after r_idx, so SEL skips disabled entries in one cycle.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (r_en[i] && (POS_W'(i) >= r_idx)) begin
        w_found = 1'b1;
        w_sel   = IDX_W'(i);
      end
    end
  end

  // Snapshot of the scan list, taken only when a pass starts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_en <= '0;
      for (int i = 0; i < NUM_CH; i++) r_chan[i] <= '0;
    end else if (w_load) begin
      r_en <= ch_en;
      for (int i = 0; i < NUM_CH; i++) r_chan[i] <= ch_list[i*CH_W +: CH_W];
    end
  end

  adc_avg_acc #(
    .DATA_W   (DATA_W),
    .AVG_LOG2 (AVG_LOG2)
  ) u_acc (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_clear    (w_clear),
    .i_add      (w_add),
    .i_data     (response_data),
    .o_full     (w_full),
    .o_avg_next (w_avg)
  );

  // Scan FSM with registered command, result and status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_tmr       <= '0;
      r_cmd_valid <= 1'b0;
      r_cmd_chan  <= '0;
      r_res_valid <= 1'b0;
      r_res_index <= '0;
      r_res_data  <= '0;
      r_scan_done <= 1'b0;
      r_err_to    <= 1'b0;
      r_err_chan  <= 1'b0;
    end else begin
      r_res_valid <= 1'b0;
      r_scan_done <= 1'b0;
      r_err_to    <= 1'b0;
      r_err_chan  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_idx   <= '0;
            r_state <= SEL;
          end
        end
        SEL: begin
          if (w_found) begin
            r_idx       <= {1'b0, w_sel};
            r_cmd_chan  <= r_chan[w_sel];
            r_cmd_valid <= 1'b1;
            r_state     <= CMD;
          end else begin
            r_scan_done <= 1'b1;
            r_state     <= END;
          end
        end
        CMD: begin
          if (command_ready) begin
            r_cmd_valid <= 1'b0;
            r_tmr       <= '0;
            r_state     <= WAIT;
          end
        end
        WAIT: begin
          if (response_valid) begin
            if (!w_match) begin
              // Wrong channel: drop the sample and ask again.
              r_err_chan  <= 1'b1;
              r_cmd_valid <= 1'b1;
              r_state     <= CMD;
            end else if (w_full) begin
              r_res_valid <= 1'b1;
              r_res_index <= r_idx[IDX_W-1:0];
              r_res_data  <= w_avg;
              r_state     <= EMIT;
            end else begin
              r_cmd_valid <= 1'b1;
              r_state     <= CMD;
            end
          end else if (w_timeout) begin
            r_err_to <= 1'b1;
            r_idx    <= r_idx + POS_W'(1);
            r_state  <= SEL;
          end else begin
            r_tmr <= r_tmr + TMR_W'(1);
          end
        end
        EMIT: begin
          r_idx   <= r_idx + POS_W'(1);
          r_state <= SEL;
        end
        END: begin
          if (continuous) begin
            r_idx   <= '0;
            r_state <= SEL;
          end else begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign command_valid         = r_cmd_valid;
  assign command_channel       = r_cmd_chan;
  assign command_startofpacket = r_cmd_valid;
  assign command_endofpacket   = r_cmd_valid;
  assign res_valid             = r_res_valid;
  assign res_index             = r_res_index;
  assign res_data              = r_res_data;
  assign busy                  = (r_state != IDLE);
  assign scan_done             = r_scan_done;
  assign err_timeout           = r_err_to;
  assign err_chan              = r_err_chan;

endmodule

// File: doc/adc_scan_ctrl.md
Name: adc_scan_ctrl

Overview:
Sequencer for the modular ADC core's Avalon-ST command/response interfaces. It scans a programmable list of ADC channels and issues one single-beat command per conversion. It accumulates 2^AVG_LOG2 conversions per list entry and emits one averaged result per entry on a simple valid-strobe output. It sits between the ADC instance and downstream math/filter logic and supports one-shot and continuous scanning with error reporting.

Parameters:
NUM_CH, 4, number of scan-list entries
CH_W, 5, ADC channel field width
DATA_W, 12, ADC sample width
AVG_LOG2, 2, log2 of samples averaged per entry (0 = no averaging)
TIMEOUT, 255, max cycles waiting for a response before abort

Ports:
clk  in  1  system clock, same as ADC clock_clk
reset_n  in  1  asynchronous active-low reset
start  in  1  pulse: begin scan when idle
continuous  in  1  restart the scan automatically after the last entry
ch_list  in  NUM_CH*CH_W  channel number per entry; entry i is at bits [i*CH_W +: CH_W]
ch_en  in  NUM_CH  per-entry enable
command_valid  out  1  to ADC command.valid
command_channel  out  CH_W  to ADC command.channel
command_startofpacket  out  1  to ADC command.startofpacket
command_endofpacket  out  1  to ADC command.endofpacket
command_ready  in  1  from ADC command.ready
response_valid  in  1  from ADC response.valid
response_channel  in  CH_W  from ADC response.channel
response_data  in  DATA_W  from ADC response.data
res_valid  out  1  one-cycle strobe: averaged result available
res_index  out  $clog2(NUM_CH)  entry index of the result
res_data  out  DATA_W  averaged sample
busy  out  1  high whenever the FSM is not in IDLE
scan_done  out  1  one-cycle pulse at the end of each scan pass
err_timeout  out  1  one-cycle pulse when an entry is aborted on timeout
err_chan  out  1  one-cycle pulse on a response whose channel does not match

Behaviour:
- Reset: all outputs 0, FSM in IDLE, index, accumulator and counters cleared. An asynchronous assert during any state aborts the operation immediately, with no partial result.
- States:
  - IDLE: on start, latch ch_list/ch_en, set idx=0, go to SEL. start outside IDLE is ignored.
  - SEL: if ch_en[idx], go to CMD. Otherwise advance idx. Past the last entry, go to END.
  - CMD: command_valid=1, command_channel=ch_list[idx], SOP=EOP=1. Hold all three stable until command_ready is high, then go to WAIT and clear the timeout counter.
  - WAIT: on response_valid:
    - channel match: acc+=response_data, cnt++. If cnt reaches 2^AVG_LOG2, go to EMIT; otherwise go to CMD.
    - channel mismatch: discard the sample, pulse err_chan, go to CMD (reissue).
    - timer hits TIMEOUT with no response: pulse err_timeout, clear acc/cnt, skip the entry (no res_valid), go to SEL with the next idx.
  - EMIT: res_valid=1 for one cycle, res_data=acc>>AVG_LOG2 (truncating), res_index=idx. Clear acc/cnt, advance idx, go to SEL.
  - END: pulse scan_done. If continuous is high, relatch ch_list/ch_en, idx=0, go to SEL; otherwise go to IDLE.
- Latency:
  - command_valid rises 2 cycles after the start pulse when entry 0 is enabled (IDLE→SEL→CMD).
  - res_valid rises 1 cycle after the final matching response.
- Accumulator width is DATA_W+AVG_LOG2, so it cannot overflow.
- All entries disabled: start → scan_done 2 cycles later, no commands issued.
- continuous deasserted mid-scan: the current pass completes, then the FSM goes to IDLE.
- response_valid outside WAIT is ignored; no error is flagged.
- Only one command is outstanding at a time.
- ch_list/ch_en changes take effect only at scan start.

Decomposition:
- Package adc_pkg holds:
  - typedef enum scan_state_t {IDLE, SEL, CMD, WAIT, EMIT, END}
  - localparam ADC_CH_W=5 and ADC_DATA_W=12
- Sub-module adc_avg_acc encapsulates the accumulator, sample counter and shift-divide, with clear/add/full interface signals.

Test Plan:
- NUM_CH=4, ch_list={3,2,1,0}, ch_en=4'b1111, AVG_LOG2=2, model returns data=100+ch after 3 cycles → four res_valid with res_data 100,101,102,103 at idx 0..3, then one scan_done, then busy=0.
- ch_en=4'b0101, samples 10,11,12,13 → only idx 0 and 2 reported, each with res_data=11 (46>>2).
- command_ready held low for 20 cycles → command_valid/channel stay stable; exactly one command is accepted.
- Model never responds on entry 1 → err_timeout pulses 256 cycles after that command is accepted; entries 0, 2 and 3 still report; scan_done is asserted.
- Response channel=7 while expecting 1 → err_chan pulses, the command is reissued with channel 1, and the average excludes the bad sample.
- continuous=1 for 2 passes then low; reset_n asserted mid-WAIT → outputs zero immediately; after release busy=0 until the next start.
